// File: rtl/conv_acc_pkg.sv
// conv_acc_pkg: shared states and sizing constants for the conv+FC frame controller.
package conv_acc_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, OUTPUT} state_t;
    localparam int N_ROWS_DEF = 26;
    localparam int FC_ADDR_W  = 5;
    localparam int N_CLASSES  = 10;
endpackage

// File: rtl/conv_row_sched_if.sv
// conv_row_sched_if: frame control, im2col row handshake, weight address and result handshake.
interface conv_row_sched_if #(
    parameter int ADDR_W = conv_acc_pkg::FC_ADDR_W,
    parameter int FCNT_W = 16
);
    logic              i_start;
    logic              i_abort;
    logic              i_row_valid;
    logic              o_row_ready;
    logic [ADDR_W-1:0] o_fc_weight_addr;
    logic              o_acc_clr;
    logic              o_acc_en;
    logic              o_res_valid;
    logic              i_res_ready;
    logic              o_busy;
    logic              o_done;
    logic [FCNT_W-1:0] o_frame_cnt;
    modport master (
        input  i_start, i_abort, i_row_valid, i_res_ready,
        output o_row_ready, o_fc_weight_addr, o_acc_clr, o_acc_en,
               o_res_valid, o_busy, o_done, o_frame_cnt
    );
    modport slave (
        output i_start, i_abort, i_row_valid, i_res_ready,
        input  o_row_ready, o_fc_weight_addr, o_acc_clr, o_acc_en,
               o_res_valid, o_busy, o_done, o_frame_cnt
    );
endinterface

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-deep 1-bit shift register with synchronous clear.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q,
    output logic o_any
);
    logic [DEPTH-1:0] r_sr;
    logic [DEPTH-1:0] w_shift;
    always_comb begin
        w_shift    = r_sr << 1;
        w_shift[0] = i_d;
    end
    // o_any looks at the contents about to be loaded, so a consumer can act on the edge the line empties
    assign o_any = |w_shift;
    assign o_q   = r_sr[DEPTH-1];
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_sr <= '0;
        else                r_sr <= w_shift;
    end
endmodule

// File: rtl/conv_row_sched.sv
// conv_row_sched: sequences one frame of N_ROWS im2col rows through the conv/FC stage
// and hands the accumulated result downstream.
module conv_row_sched
    import conv_acc_pkg::*;
#(
    parameter int N_ROWS   = N_ROWS_DEF,
    parameter int ADDR_W   = FC_ADDR_W,
    parameter int PIPE_LAT = 2,
    parameter int FCNT_W   = 16
) (
    input logic i_clk,
    input logic i_rst,
    conv_row_sched_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ROWS - 1);
    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_row_cnt;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_done;
    logic              w_accept;
    logic              w_last;
    logic              w_handshake;
    logic              w_acc_en;
    logic              w_any;
    assign w_accept    = bus.i_row_valid && (r_state == RUN);
    assign w_last      = r_row_cnt == LAST;
    assign w_handshake = (r_state == OUTPUT) && bus.i_res_ready && !bus.i_abort;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.i_start ? CLEAR : IDLE;
            CLEAR:   w_next = RUN;
            RUN:     w_next = (w_accept && w_last) ? DRAIN : RUN;
            DRAIN:   w_next = w_any ? DRAIN : OUTPUT;
            OUTPUT:  w_next = bus.i_res_ready ? IDLE : OUTPUT;
            default: w_next = IDLE;
        endcase
        if (bus.i_abort) w_next = IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_row_cnt   <= '0;
            r_frame_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_handshake;
            if (w_handshake) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (bus.i_abort || r_state == CLEAR) r_row_cnt <= '0;
            else if (w_accept && !w_last)        r_row_cnt <= r_row_cnt + 1'b1;
        end
    end
    valid_delay_line #(.DEPTH(PIPE_LAT)) u_dly (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (bus.i_abort),
        .i_d   (w_accept),
        .o_q   (w_acc_en),
        .o_any (w_any)
    );
    assign bus.o_row_ready      = r_state == RUN;
    assign bus.o_fc_weight_addr = r_row_cnt;
    assign bus.o_acc_clr        = r_state == CLEAR;
    assign bus.o_acc_en         = w_acc_en;
    assign bus.o_res_valid      = r_state == OUTPUT;
    assign bus.o_busy           = r_state != IDLE;
    assign bus.o_done           = r_done;
    assign bus.o_frame_cnt      = r_frame_cnt;
endmodule
